// File: rtl/msgpass_buff_rd_ctrl.sv
// Read-issue stage for the message-pass buffer: issues RAM reads, realigns returned data with its DRC tag
// and buffers results in a credit-protected FIFO. Define MSGPASS_RD_CTRL_ERR_CHK_EN to build the request-stability checker.
module msgpass_buff_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DRC_NUM    = 2,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  rd_rqst_valid_i,
  output logic                  rd_rqst_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DRC_NUM-1:0]    is_drc_i,
  output logic                  mem_ren_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DRC_NUM-1:0]    rd_drc_o,
  output logic                  err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]      outstanding;
  logic                  accept, push, pop, empty, full;
  logic [RD_LAT-1:0]     pipe_vld;
  logic [DRC_NUM-1:0]    pipe_drc [RD_LAT];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [DRC_NUM-1:0]    fifo_drc  [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;

  // Credit check uses only the registered counter, so a pop frees its slot one cycle later.
  assign rd_rqst_ready_o = !rst && !flush_i && (outstanding < CNT_W'(FIFO_DEPTH));
  assign accept          = rd_rqst_valid_i && rd_rqst_ready_o;
  assign mem_ren_o       = accept;
  assign mem_raddr_o     = accept ? rd_addr_i : '0;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push  = pipe_vld[RD_LAT-1] && !flush_i;
  assign pop   = !empty && rd_ready_i && !flush_i;

  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : fifo_data[rd_ptr[PTR_W-1:0]];
  assign rd_drc_o   = empty ? '0 : fifo_drc[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_drc[i] <= '0;
    end else begin
      for (int unsigned i = RD_LAT - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1] && !flush_i;
        pipe_drc[i] <= pipe_drc[i-1];
      end
      pipe_vld[0] <= accept;
      pipe_drc[0] <= is_drc_i;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) begin
        assert (!full);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: head outputs are masked while the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_data[wr_ptr[PTR_W-1:0]] <= mem_rdata_i;
      fifo_drc[wr_ptr[PTR_W-1:0]]  <= pipe_drc[RD_LAT-1];
    end
  end

`ifdef MSGPASS_RD_CTRL_ERR_CHK_EN
  logic                  stall_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DRC_NUM-1:0]    drc_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      drc_q   <= '0;
    end else begin
      stall_q <= rd_rqst_valid_i && !rd_rqst_ready_o;
      addr_q  <= rd_addr_i;
      drc_q   <= is_drc_i;
      if (stall_q && (!rd_rqst_valid_i || rd_addr_i != addr_q || is_drc_i != drc_q))
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_msgpass_buff_rd_ctrl.sv
// Randomized scoreboard bench for msgpass_buff_rd_ctrl: queue-based reference model of accepted reads,
// behavioural RAM with fixed latency, and an output monitor that pops and compares.
module tb_msgpass_buff_rd_ctrl;
  localparam int unsigned AW = 8, DW = 32, DN = 2, LAT = 2, DEPTH = 4;
  localparam bit ERR_EN =
`ifdef MSGPASS_RD_CTRL_ERR_CHK_EN
    1'b1;
`else
    1'b0;
`endif

  logic sys_clk = 1'b0, rst, flush_i, rd_rqst_valid_i, rd_rqst_ready_o, mem_ren_o;
  logic rd_valid_o, rd_ready_i, err_o;
  logic [AW-1:0] rd_addr_i, mem_raddr_o;
  logic [DN-1:0] is_drc_i, rd_drc_o;
  logic [DW-1:0] mem_rdata_i = '0, rd_data_o;

  msgpass_buff_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRC_NUM(DN), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst(rst), .flush_i(flush_i),
    .rd_rqst_valid_i(rd_rqst_valid_i), .rd_rqst_ready_o(rd_rqst_ready_o),
    .rd_addr_i(rd_addr_i), .is_drc_i(is_drc_i),
    .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_drc_o(rd_drc_o),
    .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [DW-1:0] data; logic [DN-1:0] drc; int unsigned due; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int unsigned cyc = 0, qsz = 0;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rstage [LAT];
  bit acc_f, pop_f, rst_f, flush_f, stall_f, viol_f, prev_stall, err_m;
  logic [AW-1:0] prev_addr, addr_f;
  logic [DN-1:0] prev_drc, drc_f;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RAM: data for a read issued in cycle c is presented throughout cycle c+LAT, garbage otherwise.
  always @(negedge sys_clk) begin
    for (int k = LAT - 1; k > 0; k--) rstage[k] = rstage[k-1];
    rstage[0] = mem_ren_o ? ram[mem_raddr_o] : $urandom;
  end
  always @(posedge sys_clk) begin
    #1;
    mem_rdata_i = rstage[LAT-1];
  end

  // Issue side: predicts ready from the credit rule, records accepted reads with their due cycle.
  always @(negedge sys_clk) begin
    bit m_ready;
    rst_f = rst; flush_f = flush_i; addr_f = rd_addr_i; drc_f = is_drc_i;
    acc_f = 1'b0; stall_f = 1'b0; viol_f = 1'b0;
    if (rst) begin
      chk("ready_rst", rd_rqst_ready_o, 0);
      chk("ren_rst", mem_ren_o, 0);
      chk("raddr_rst", mem_raddr_o, 0);
    end else begin
      m_ready = !flush_i && (qsz < DEPTH);
      chk("ready", rd_rqst_ready_o, m_ready);
      acc_f = rd_rqst_valid_i && m_ready;
      chk("ren", mem_ren_o, acc_f);
      chk("raddr", mem_raddr_o, acc_f ? rd_addr_i : '0);
      if (acc_f) exp_q.push_back('{data: ram[rd_addr_i], drc: is_drc_i, due: cyc + LAT + 1});
      stall_f = rd_rqst_valid_i && !m_ready;
      viol_f = prev_stall && (!rd_rqst_valid_i || rd_addr_i != prev_addr || is_drc_i != prev_drc);
    end
  end

  // Output monitor: the head is visible once its due cycle is reached.
  always @(negedge sys_clk) begin
    bit exp_v;
    pop_f = 1'b0;
    if (rst) begin
      chk("valid_rst", rd_valid_o, 0);
      chk("data_rst", rd_data_o, 0);
      chk("drc_rst", rd_drc_o, 0);
      chk("err_rst", err_o, 0);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      chk("rd_valid", rd_valid_o, exp_v);
      chk("err", err_o, err_m);
      if (exp_v) begin
        chk("rd_data", rd_data_o, exp_q[0].data);
        chk("rd_drc", rd_drc_o, exp_q[0].drc);
        if (rd_ready_i && !flush_i) begin
          pop_f = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge sys_clk) begin
    cyc++;
    if (rst_f) begin
      exp_q.delete();
      err_m = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (flush_f) exp_q.delete();
      if (ERR_EN && viol_f) err_m = 1'b1;
      prev_stall = stall_f;
      prev_addr = addr_f;
      prev_drc = drc_f;
    end
    qsz = exp_q.size();
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DN-1:0] d);
    rd_rqst_valid_i = 1'b1; rd_addr_i = a; is_drc_i = d;
    for (int n = 0; n < 40; n++) begin
      step();
      if (acc_f) return;
    end
    chk("send_timeout", 64'(a), 64'hFFFF_FFFF);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; rd_rqst_valid_i = 1'b0; rd_addr_i = '0; is_drc_i = '0; rd_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[5] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      rd_rqst_valid_i = 1'($urandom); rd_addr_i = AW'($urandom); is_drc_i = DN'($urandom);
      rd_ready_i = 1'($urandom); flush_i = 1'($urandom);
    end
    step();
    rst = 1'b0; flush_i = 1'b0; rd_rqst_valid_i = 1'b0; rd_ready_i = 1'b1;
    step();

    send(8'h05, 2'b00);
    rd_rqst_valid_i = 1'b0;
    repeat (5) step();

    rd_ready_i = 1'b0;
    for (int a = 0; a < 4; a++) send(AW'(a), DN'(a));
    rd_rqst_valid_i = 1'b1; rd_addr_i = 8'd4; is_drc_i = 2'd0;
    repeat (4) step();
    rd_ready_i = 1'b1;
    for (int a = 4; a < 8; a++) send(AW'(a), DN'(a));
    rd_rqst_valid_i = 1'b0;
    repeat (10) step();

    send(8'h03, 2'b10);
    send(8'h04, 2'b00);
    rd_rqst_valid_i = 1'b0;
    repeat (6) step();

    rd_ready_i = 1'b0;
    send(8'h08, 2'b01); send(8'h09, 2'b10); send(8'h0A, 2'b11);
    rd_rqst_valid_i = 1'b0; flush_i = 1'b1; rd_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) send(AW'(8'h20 + i), DN'(i));
    rd_rqst_valid_i = 1'b0;
    repeat (8) step();

    for (int i = 0; i < 2500; i++) begin
      if (!(rd_rqst_valid_i && !acc_f)) begin
        rd_rqst_valid_i = ($urandom_range(0, 9) < 7);
        rd_addr_i = AW'($urandom);
        is_drc_i = DN'($urandom);
      end
      rd_ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; flush_i = 1'b0; rd_rqst_valid_i = 1'b0; rd_ready_i = 1'b1;
    repeat (10) step();

`ifdef MSGPASS_RD_CTRL_ERR_CHK_EN
    rd_ready_i = 1'b0;
    for (int a = 0; a < 4; a++) send(AW'(8'h40 + a), 2'b00);
    rd_rqst_valid_i = 1'b1; rd_addr_i = 8'h10; is_drc_i = 2'b00;
    step();
    rd_addr_i = 8'h11;
    step();
    rd_rqst_valid_i = 1'b0;
    repeat (2) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; rd_ready_i = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
`endif

    rd_rqst_valid_i = 1'b0; rd_ready_i = 1'b1;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msgpass_buff_rd_ctrl.md
Name: msgpass_buff_rd_ctrl

Overview:
- Read-issue stage directly downstream of the message-pass buffer address generator.
- Accepts read requests (address plus DRC tag) through a valid/ready handshake and issues them to the message-pass buffer RAM, which has a fixed read latency.
- Tracks in-flight reads, realigns returned data with its DRC tag, and buffers the results in a small output FIFO.
- Uses credit-based flow control so that no returned read is ever dropped under consumer backpressure.

Parameters:
- ADDR_WIDTH, 8: message-pass buffer address width.
- DATA_WIDTH, 32: buffer word width.
- DRC_NUM, 2: width of the DRC tag; matches the memShare DRC count.
- RD_LAT, 2: RAM read latency in cycles, from mem_ren_o to valid mem_rdata_i. Legal range 1..8.
- FIFO_DEPTH, 4: output FIFO entries. Power of two, at least 2.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush; discards in-flight reads and FIFO contents.
- rd_rqst_valid_i  in  1  request valid.
- rd_rqst_ready_o  out  1  request accepted when valid and ready are both high.
- rd_addr_i  in  ADDR_WIDTH  request address.
- is_drc_i  in  DRC_NUM  request DRC tag.
- mem_ren_o  out  1  RAM read enable.
- mem_raddr_o  out  ADDR_WIDTH  RAM read address.
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid RD_LAT cycles after mem_ren_o.
- rd_valid_o  out  1  output FIFO head valid.
- rd_ready_i  in  1  consumer ready.
- rd_data_o  out  DATA_WIDTH  read data.
- rd_drc_o  out  DRC_NUM  DRC tag belonging to rd_data_o.
- err_o  out  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, in-flight pipe cleared, FIFO empty, outstanding counter 0.
- Accept condition: accept = rd_rqst_valid_i & rd_rqst_ready_o.
- Request issue is combinational: mem_ren_o = accept and mem_raddr_o = rd_addr_i. mem_raddr_o is 0 when there is no accept.
- Tag pipe: an RD_LAT-stage shift register of {valid, drc}. Stage 0 loads {accept, is_drc_i} on each edge.
- Capture: when the final pipe stage is valid, mem_rdata_i and its tag are pushed into the FIFO on that cycle's edge.
- End-to-end latency: a request accepted in cycle T produces rd_valid_o=1 in cycle T+RD_LAT+1, provided the FIFO was empty.
- FIFO output: rd_valid_o = !empty. rd_data_o and rd_drc_o drive the FIFO head. A pop occurs when rd_valid_o & rd_ready_i.
- FIFO ordering is strictly FIFO; read and write pointers wrap modulo FIFO_DEPTH.
- Outstanding counter:
  - outstanding = in-flight valid reads + FIFO occupancy; width clog2(FIFO_DEPTH+1).
  - Updated by +accept and -pop each cycle; a simultaneous accept and pop leaves it unchanged.
- Ready rule: rd_rqst_ready_o = !rst & !flush_i & (outstanding < FIFO_DEPTH), computed from the registered counter.
  - A pop in cycle N frees its credit in cycle N+1, not in cycle N.
- Full/empty: because of the credit rule the FIFO can never overflow. A push into a full FIFO is unreachable and is asserted against in simulation.
  - A pop on empty is impossible, since rd_valid_o is 0 whenever the FIFO is empty.
- Flush: when flush_i=1 at an edge, the following are cleared:
  - all tag pipe valid bits;
  - the FIFO pointers;
  - the outstanding counter.
- During the flush cycle: rd_rqst_ready_o=0 and no accept occurs. A pop in the same cycle is ignored.
- After a flush, RAM data returning for flushed reads is discarded because its pipe valid bit has been cleared.
- Reset mid-operation: asynchronously returns every register to its reset value. Outputs take their reset values immediately.
- Timing: no combinational path from rd_ready_i to rd_rqst_ready_o.

Optional Feature:
- Macro name: MSGPASS_RD_CTRL_ERR_CHK_EN.
- When defined, a request-stability checker is built:
  - If rd_rqst_valid_i=1 and rd_rqst_ready_o=0 in cycle N, then in cycle N+1 rd_rqst_valid_i must still be 1 and rd_addr_i and is_drc_i must be unchanged.
  - Any violation sets err_o=1 on the next edge.
  - err_o is sticky until rst; flush_i does not clear it.
- When not defined, err_o is tied to 0 and no checker logic is built.

Test Plan (RD_LAT=2, FIFO_DEPTH=4, DATA_WIDTH=32):
- Reset: hold rst=1 for 3 cycles with random inputs -> all outputs 0 and rd_rqst_ready_o=0. After release -> rd_rqst_ready_o=1, rd_valid_o=0.
- Single read: accept addr 0x05, tag 2'b00 at cycle T -> mem_ren_o=1 and mem_raddr_o=0x05 at T. Drive mem_rdata_i=0xDEADBEEF at T+2 -> at T+3, rd_valid_o=1 and rd_data_o=0xDEADBEEF.
- Backpressure: rd_ready_i=0, offer addrs 0..7 back-to-back, RAM returns data=addr -> exactly addrs 0..3 accepted, rd_rqst_ready_o=0 from the cycle after the 4th accept. Then raise rd_ready_i=1 -> data 0..7 emerge in order, with none lost or duplicated.
- DRC tag alignment: interleave addr 3 with tag 2'b10 and addr 4 with tag 2'b00 -> rd_drc_o=2'b10 with data 3, then rd_drc_o=2'b00 with data 4.
- Flush: 2 reads in flight and 1 in the FIFO, pulse flush_i for one cycle -> next cycle rd_valid_o=0 and rd_rqst_ready_o=1. No flushed data ever appears; 4 new requests are accepted without stall.
- Error check (macro defined): valid=1 with addr 0x10 while stalled, then change addr to 0x11 -> err_o=1 on the following cycle and stays 1 through a flush until rst.
